mc_ctrl_320: RTL and testbench
==============================

MC_CTRL_320 -- requirements
Module: mc_ctrl_320

Interface
REQ-001 Parameter TRAP_EN, default 1, meaning: 1 enables the signed-overflow trap on add/addi; 0 ignores the overflow flag.
REQ-002 Port clk, input, 1, rising-edge system clock.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Port instr, input, 32, instruction register contents; valid from ID onward.
REQ-005 Port zero, sml, overflow, input, 1 each, ALU flags, sampled in EX.
REQ-006 Port mem_ready, input, 1, memory acknowledge for the current mem_req.
REQ-007 Port alu_op, output, 5; encoding: 0 add, 1 sub, 2 slt, 3 and, 4 nor, 5 or, 6 xor, 7 sll, 8 srl, 9 sltu, 10 jalr, 11 jr, 12 sllv, 13 sra, 14 srav, 15 srlv, 16 lui.
REQ-008 Ports mem_req, mem_we, ir_we, pc_we, reg_we, output, 1 each, strobes.
REQ-009 Ports src_a (0 rs, 1 shamt), src_b (0 rt, 1 sign-ext imm, 2 zero-ext imm, 3 const 4), wb_sel (0 alu, 1 mem, 2 pc+4), dst_sel (0 rt, 1 rd, 2 $31), pc_sel (0 pc+4, 1 branch, 2 jump, 3 rs), output, 2 bits each.
REQ-010 Port trap, output, 1, sticky illegal-instruction/overflow flag; state, output, 3, current FSM state.

Function
REQ-011 FSM states: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5; all outputs are a registered-state Moore decode plus the instr fields.
REQ-012 IF: mem_req=1, ir_we=mem_ready, pc_we=mem_ready, pc_sel=0; stay in IF while mem_ready=0; go to ID when mem_ready=1.
REQ-013 ID: decode the opcode/funct; go to HALT with trap=1 if the encoding is unsupported, otherwise go to EX.
REQ-014 Supported set: R-type add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav, jr, jalr; addi, addiu, slti, sltiu, andi, ori, xori, lui, lw, sw, beq, bne, j, jal.
REQ-015 EX drives alu_op and src_a/src_b per the instruction.
- Shifts by shamt: src_a=1.
- andi, ori, xori: src_b=2.
- Other immediates: src_b=1.
- lui: op 16.
- beq/bne: op 1.
REQ-016 EX, branches: pc_we=1 and pc_sel=1 iff (beq and zero) or (bne and !zero); next state IF; total 3 cycles.
REQ-017 EX, j/jal: pc_sel=2, pc_we=1; jal also reg_we=1, dst_sel=2, wb_sel=2; next state IF.
REQ-018 EX, jr/jalr: pc_sel=3, pc_we=1; jalr writes rd with pc+4; next state IF.
REQ-019 EX, lw/sw: next state MEM. All other instructions: next state WB.
REQ-020 MEM: mem_req=1, mem_we=sw; wait while mem_ready=0.
- sw: go to IF on mem_ready.
- lw: go to WB on mem_ready.
REQ-021 WB: reg_we=1, then go to IF.
- lw: wb_sel=1, dst_sel=0.
- R-type: dst_sel=1.
- Immediates: dst_sel=0.
REQ-022 Overflow, sampled in EX for add/addi only: if TRAP_EN=1 and overflow=1, go to HALT with reg_we never asserted for that instruction.
REQ-023 HALT is absorbing. All strobes are 0, trap=1, and only reset exits.
REQ-024 Strobes are 0 in every state not listed above. mem_req is never asserted in ID, EX or WB.
REQ-025 Cycle counts with zero-wait memory:
- R-type/immediate: 4.
- lw: 5.
- sw: 4.
- branch/jump: 3.
Each wait cycle adds 1.

Reset
REQ-026 rst_n=0 forces state=IF and trap=0 immediately, regardless of clk; all strobes deassert combinationally.
REQ-027 Reset asserted mid-MEM abandons the access. After release, the first cycle is IF with mem_req=1.

Structure
REQ-028 A shared package holds the state encodings, the alu_op constants, and the mux-select encodings. The ALU and the datapath import the same constants.
REQ-029 One sub-module, mc_decode_320, is combinational: {opcode, funct} -> {class, alu_op, src_a, src_b, dst_sel, legal}. The FSM stays in mc_ctrl_320.

Verification
REQ-030 addu $3,$1,$2 (0x00221821), mem_ready=1 -> states IF,ID,EX,WB,IF; alu_op=0, dst_sel=1, reg_we high in exactly 1 cycle.
REQ-031 lw (0x8C220004) with mem_ready low for 2 cycles in MEM -> 7 cycles total; wb_sel=1 in WB; mem_we=0 throughout.
REQ-032 beq with zero=1, then zero=0 -> pc_we=1, pc_sel=1 in EX for the first; pc_we=0 in EX for the second; both take 3 cycles.
REQ-033 add with overflow=1, TRAP_EN=1 -> HALT, trap=1, reg_we never asserted. Same case with TRAP_EN=0 -> WB with reg_we=1.
REQ-034 Opcode 0x3F -> HALT after ID. Then rst_n low for 1 cycle mid-HALT -> state=IF, trap=0.
REQ-035 sw with rst_n asserted during MEM wait -> mem_req drops asynchronously; after release the FSM resumes in IF.

Source files
------------

// File: rtl/mc_ctrl_320_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, ALU
// operation codes, datapath mux selects, instruction classes and opcodes.
package mc_ctrl_320_pkg;

  // FSM state encoding, also visible on the state output port
  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_e;

  // ALU operation codes shared with the ALU
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLT  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_NOR  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_SLL  = 5'd7;
  localparam logic [4:0] ALU_SRL  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_JALR = 5'd10;
  localparam logic [4:0] ALU_JR   = 5'd11;
  localparam logic [4:0] ALU_SLLV = 5'd12;
  localparam logic [4:0] ALU_SRA  = 5'd13;
  localparam logic [4:0] ALU_SRAV = 5'd14;
  localparam logic [4:0] ALU_SRLV = 5'd15;
  localparam logic [4:0] ALU_LUI  = 5'd16;

  // Datapath mux selects
  localparam logic [1:0] SRCA_RS    = 2'd0;
  localparam logic [1:0] SRCA_SHAMT = 2'd1;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_SEXT  = 2'd1;
  localparam logic [1:0] SRCB_ZEXT  = 2'd2;
  localparam logic [1:0] SRCB_FOUR  = 2'd3;

  localparam logic [1:0] WB_ALU     = 2'd0;
  localparam logic [1:0] WB_MEM     = 2'd1;
  localparam logic [1:0] WB_PC4     = 2'd2;

  localparam logic [1:0] DST_RT     = 2'd0;
  localparam logic [1:0] DST_RD     = 2'd1;
  localparam logic [1:0] DST_RA     = 2'd2;

  localparam logic [1:0] PC_PLUS4   = 2'd0;
  localparam logic [1:0] PC_BRANCH  = 2'd1;
  localparam logic [1:0] PC_JUMP    = 2'd2;
  localparam logic [1:0] PC_RS      = 2'd3;

  // Instruction classes that steer the FSM
  typedef enum logic [3:0] {
    CL_ALU  = 4'd0,
    CL_LW   = 4'd1,
    CL_SW   = 4'd2,
    CL_BEQ  = 4'd3,
    CL_BNE  = 4'd4,
    CL_J    = 4'd5,
    CL_JAL  = 4'd6,
    CL_JR   = 4'd7,
    CL_JALR = 4'd8
  } class_e;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // Classes that finish in EX by redirecting (or not) the PC
  function automatic logic is_flow_class(input class_e c);
    return (c == CL_BEQ) || (c == CL_BNE) || (c == CL_J) ||
           (c == CL_JAL) || (c == CL_JR)  || (c == CL_JALR);
  endfunction

endpackage

// File: rtl/mc_ctrl_320_decode.sv
// Combinational instruction decoder: {opcode, funct} to class, ALU op,
// operand selects, destination select and legality. Also flags add/addi
// as the only instructions that honour the signed-overflow trap.
module mc_decode_320
  import mc_ctrl_320_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output class_e     o_class,
  output logic [4:0] o_alu_op,
  output logic [1:0] o_src_a,
  output logic [1:0] o_src_b,
  output logic [1:0] o_dst_sel,
  output logic       o_legal,
  output logic       o_ovf_chk
);

  // Table lookup of the supported instruction set; anything else is illegal
  always_comb begin
    o_class   = CL_ALU;
    o_alu_op  = ALU_ADD;
    o_src_a   = SRCA_RS;
    o_src_b   = SRCB_RT;
    o_dst_sel = DST_RT;
    o_legal   = 1'b1;
    o_ovf_chk = 1'b0;
    case (i_opcode)
      OP_RTYPE: begin
        o_dst_sel = DST_RD;
        case (i_funct)
          FN_ADD:  begin o_alu_op = ALU_ADD; o_ovf_chk = 1'b1; end
          FN_ADDU: o_alu_op = ALU_ADD;
          FN_SUB:  o_alu_op = ALU_SUB;
          FN_SUBU: o_alu_op = ALU_SUB;
          FN_AND:  o_alu_op = ALU_AND;
          FN_OR:   o_alu_op = ALU_OR;
          FN_XOR:  o_alu_op = ALU_XOR;
          FN_NOR:  o_alu_op = ALU_NOR;
          FN_SLT:  o_alu_op = ALU_SLT;
          FN_SLTU: o_alu_op = ALU_SLTU;
          FN_SLL:  begin o_alu_op = ALU_SLL; o_src_a = SRCA_SHAMT; end
          FN_SRL:  begin o_alu_op = ALU_SRL; o_src_a = SRCA_SHAMT; end
          FN_SRA:  begin o_alu_op = ALU_SRA; o_src_a = SRCA_SHAMT; end
          FN_SLLV: o_alu_op = ALU_SLLV;
          FN_SRLV: o_alu_op = ALU_SRLV;
          FN_SRAV: o_alu_op = ALU_SRAV;
          FN_JR:   begin o_class = CL_JR;   o_alu_op = ALU_JR;   end
          FN_JALR: begin o_class = CL_JALR; o_alu_op = ALU_JALR; end
          default: o_legal = 1'b0;
        endcase
      end
      OP_ADDI:  begin o_alu_op = ALU_ADD;  o_src_b = SRCB_SEXT; o_ovf_chk = 1'b1; end
      OP_ADDIU: begin o_alu_op = ALU_ADD;  o_src_b = SRCB_SEXT; end
      OP_SLTI:  begin o_alu_op = ALU_SLT;  o_src_b = SRCB_SEXT; end
      OP_SLTIU: begin o_alu_op = ALU_SLTU; o_src_b = SRCB_SEXT; end
      OP_ANDI:  begin o_alu_op = ALU_AND;  o_src_b = SRCB_ZEXT; end
      OP_ORI:   begin o_alu_op = ALU_OR;   o_src_b = SRCB_ZEXT; end
      OP_XORI:  begin o_alu_op = ALU_XOR;  o_src_b = SRCB_ZEXT; end
      OP_LUI:   begin o_alu_op = ALU_LUI;  o_src_b = SRCB_SEXT; end
      OP_LW:    begin o_class = CL_LW; o_alu_op = ALU_ADD; o_src_b = SRCB_SEXT; end
      OP_SW:    begin o_class = CL_SW; o_alu_op = ALU_ADD; o_src_b = SRCB_SEXT; end
      // Branch compares rs against rt by subtraction; the ALU zero flag decides
      OP_BEQ:   begin o_class = CL_BEQ; o_alu_op = ALU_SUB; end
      OP_BNE:   begin o_class = CL_BNE; o_alu_op = ALU_SUB; end
      OP_J:     o_class = CL_J;
      OP_JAL:   begin o_class = CL_JAL; o_dst_sel = DST_RA; end
      default:  o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_320.sv
// Multi-cycle MIPS control unit: IF/ID/EX/MEM/WB FSM with a sticky HALT
// state entered on illegal encodings or (optionally) add/addi overflow.
// Outputs are a Moore decode of the registered state plus instr fields.
module mc_ctrl_320
  import mc_ctrl_320_pkg::*;
#(
  parameter bit TRAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        sml,
  input  logic        overflow,
  input  logic        mem_ready,
  output logic [4:0]  alu_op,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic [1:0]  src_a,
  output logic [1:0]  src_b,
  output logic [1:0]  wb_sel,
  output logic [1:0]  dst_sel,
  output logic [1:0]  pc_sel,
  output logic        trap,
  output logic [2:0]  state
);

  state_e     r_state;
  state_e     w_next;
  logic       r_trap;

  class_e     w_class;
  logic [4:0] w_alu_op;
  logic [1:0] w_src_a;
  logic [1:0] w_src_b;
  logic [1:0] w_dst_sel;
  logic       w_legal;
  logic       w_ovf_chk;

  logic       w_mem_req;
  logic       w_mem_we;
  logic       w_ir_we;
  logic       w_pc_we;
  logic       w_reg_we;

  // sml and the register/immediate fields are consumed by the datapath only
  logic       w_unused;
  assign w_unused = &{1'b0, sml, instr[25:6]};

  mc_decode_320 u_decode (
    .i_opcode  (instr[31:26]),
    .i_funct   (instr[5:0]),
    .o_class   (w_class),
    .o_alu_op  (w_alu_op),
    .o_src_a   (w_src_a),
    .o_src_b   (w_src_b),
    .o_dst_sel (w_dst_sel),
    .o_legal   (w_legal),
    .o_ovf_chk (w_ovf_chk)
  );

  // State register and sticky trap flag; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IF;
      r_trap  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == ST_HALT) r_trap <= 1'b1;
    end
  end

  // Next-state selection from the current state, decode and handshakes
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IF:   if (mem_ready) w_next = ST_ID;
      ST_ID:   w_next = w_legal ? ST_EX : ST_HALT;
      ST_EX: begin
        if ((w_class == CL_LW) || (w_class == CL_SW)) begin
          w_next = ST_MEM;
        end else if (is_flow_class(w_class)) begin
          w_next = ST_IF;
        end else if (TRAP_EN && w_ovf_chk && overflow) begin
          // Trapped add/addi never reaches WB, so the register file is untouched
          w_next = ST_HALT;
        end else begin
          w_next = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ready) w_next = (w_class == CL_SW) ? ST_IF : ST_WB;
      end
      ST_WB:   w_next = ST_IF;
      ST_HALT: w_next = ST_HALT;
      default: w_next = ST_IF;
    endcase
  end

  // Moore output decode: strobes and mux selects per state and instruction
  always_comb begin
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_ir_we   = 1'b0;
    w_pc_we   = 1'b0;
    w_reg_we  = 1'b0;
    alu_op    = ALU_ADD;
    src_a     = SRCA_RS;
    src_b     = SRCB_RT;
    wb_sel    = WB_ALU;
    dst_sel   = DST_RT;
    pc_sel    = PC_PLUS4;
    case (r_state)
      ST_IF: begin
        w_mem_req = 1'b1;
        w_ir_we   = mem_ready;
        w_pc_we   = mem_ready;
      end
      ST_EX: begin
        alu_op = w_alu_op;
        src_a  = w_src_a;
        src_b  = w_src_b;
        case (w_class)
          CL_BEQ: if (zero) begin
            w_pc_we = 1'b1;
            pc_sel  = PC_BRANCH;
          end
          CL_BNE: if (!zero) begin
            w_pc_we = 1'b1;
            pc_sel  = PC_BRANCH;
          end
          CL_J: begin
            w_pc_we = 1'b1;
            pc_sel  = PC_JUMP;
          end
          CL_JAL: begin
            w_pc_we  = 1'b1;
            pc_sel   = PC_JUMP;
            w_reg_we = 1'b1;
            dst_sel  = DST_RA;
            wb_sel   = WB_PC4;
          end
          CL_JR: begin
            w_pc_we = 1'b1;
            pc_sel  = PC_RS;
          end
          CL_JALR: begin
            w_pc_we  = 1'b1;
            pc_sel   = PC_RS;
            w_reg_we = 1'b1;
            dst_sel  = DST_RD;
            wb_sel   = WB_PC4;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        w_mem_req = 1'b1;
        w_mem_we  = (w_class == CL_SW);
      end
      ST_WB: begin
        w_reg_we = 1'b1;
        dst_sel  = w_dst_sel;
        wb_sel   = (w_class == CL_LW) ? WB_MEM : WB_ALU;
      end
      default: ;
    endcase
  end

  // Strobes are forced low combinationally while reset is held
  assign mem_req = w_mem_req & rst_n;
  assign mem_we  = w_mem_we  & rst_n;
  assign ir_we   = w_ir_we   & rst_n;
  assign pc_we   = w_pc_we   & rst_n;
  assign reg_we  = w_reg_we  & rst_n;

  assign trap    = r_trap;
  assign state   = r_state;

endmodule

// File: tb/tb_mc_ctrl_320.sv
// Directed bench for mc_ctrl_320: a table of single-instruction vectors
// plus hand-written sequences for trap, HALT and asynchronous reset cases.
module tb_mc_ctrl_320;
  import mc_ctrl_320_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0, sml = 1'b0, overflow = 1'b0, mem_ready = 1'b0;

  logic [4:0] alu_op0, alu_op1;
  logic       mem_req0, mem_we0, ir_we0, pc_we0, reg_we0, trap0;
  logic       mem_req1, mem_we1, ir_we1, pc_we1, reg_we1, trap1;
  logic [1:0] src_a0, src_b0, wb_sel0, dst_sel0, pc_sel0;
  logic [1:0] src_a1, src_b1, wb_sel1, dst_sel1, pc_sel1;
  logic [2:0] state0, state1;

  mc_ctrl_320 #(.TRAP_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .sml(sml),
    .overflow(overflow), .mem_ready(mem_ready), .alu_op(alu_op0),
    .mem_req(mem_req0), .mem_we(mem_we0), .ir_we(ir_we0), .pc_we(pc_we0),
    .reg_we(reg_we0), .src_a(src_a0), .src_b(src_b0), .wb_sel(wb_sel0),
    .dst_sel(dst_sel0), .pc_sel(pc_sel0), .trap(trap0), .state(state0)
  );

  mc_ctrl_320 #(.TRAP_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .sml(sml),
    .overflow(overflow), .mem_ready(mem_ready), .alu_op(alu_op1),
    .mem_req(mem_req1), .mem_we(mem_we1), .ir_we(ir_we1), .pc_we(pc_we1),
    .reg_we(reg_we1), .src_a(src_a1), .src_b(src_b1), .wb_sel(wb_sel1),
    .dst_sel(dst_sel1), .pc_sel(pc_sel1), .trap(trap1), .state(state1)
  );

  // Observed instance: 0 = TRAP_EN=1, 1 = TRAP_EN=0
  logic       sel = 1'b0;
  logic [4:0] o_alu;
  logic       o_mem_req, o_mem_we, o_pc_we, o_reg_we, o_trap;
  logic [1:0] o_sa, o_sb, o_wb, o_dst, o_pcsel;
  logic [2:0] o_state;
  assign o_alu     = sel ? alu_op1  : alu_op0;
  assign o_mem_req = sel ? mem_req1 : mem_req0;
  assign o_mem_we  = sel ? mem_we1  : mem_we0;
  assign o_pc_we   = sel ? pc_we1   : pc_we0;
  assign o_reg_we  = sel ? reg_we1  : reg_we0;
  assign o_trap    = sel ? trap1    : trap0;
  assign o_sa      = sel ? src_a1   : src_a0;
  assign o_sb      = sel ? src_b1   : src_b0;
  assign o_wb      = sel ? wb_sel1  : wb_sel0;
  assign o_dst     = sel ? dst_sel1 : dst_sel0;
  assign o_pcsel   = sel ? pc_sel1  : pc_sel0;
  assign o_state   = sel ? state1   : state0;

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int rwe0_cnt = 0;

  always @(negedge clk) if (reg_we0) rwe0_cnt <= rwe0_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  typedef struct {
    int         cyc;
    int         nregwe;
    logic [4:0] alu;
    logic [1:0] sa, sb, pcsel, dst, wb;
    logic       pcwe, memwe;
    logic [2:0] st_end;
  } obs_t;

  typedef struct {
    logic [31:0] ins;
    logic        z, ov;
    int          mwait;
    int          cyc, nregwe;
    logic [4:0]  alu;
    logic [1:0]  sa, sb;
    logic        pcwe;
    logic [1:0]  pcsel, dst, wb;
    logic        memwe;
  } vec_t;

  // Runs one instruction from IF until the next IF (held there) or HALT.
  task automatic run_instr(input logic [31:0] ins, input logic z, input logic ov,
                           input int mwait, output obs_t o);
    int  mcnt;
    bit  done;
    o = '{cyc: 0, nregwe: 0, alu: '0, sa: '0, sb: '0, pcsel: '0, dst: '0,
          wb: '0, pcwe: 1'b0, memwe: 1'b0, st_end: '0};
    mcnt = 0;
    done = 1'b0;
    instr = ins;
    zero = z;
    overflow = ov;
    while (!done && o.cyc < 40) begin
      @(negedge clk);
      if (o_state == ST_HALT || (o_state == ST_IF && o.cyc > 0)) begin
        mem_ready = 1'b0;
        done = 1'b1;
      end else begin
        mem_ready = (o_state == ST_MEM) ? (mcnt >= mwait) : 1'b1;
        #1;
        o.cyc++;
        if (o_state == ST_MEM) mcnt++;
        if (o_mem_we) o.memwe = 1'b1;
        if (o_reg_we) begin
          o.nregwe++;
          o.dst = o_dst;
          o.wb  = o_wb;
        end
        if (o_state == ST_EX) begin
          o.alu   = o_alu;
          o.sa    = o_sa;
          o.sb    = o_sb;
          o.pcwe  = o_pc_we;
          o.pcsel = o_pcsel;
        end
      end
    end
    if (!done) begin
      o.cyc = -1;
      $display("FAIL run_timeout instr=%h actual=timeout required=completion", ins);
    end
    o.st_end = o_state;
  endtask

  localparam int NV = 16;
  vec_t vt[NV];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int   c0;

    //             ins          z     ov  mw cyc rwe alu    sa    sb  pcwe pcsel dst  wb  memwe
    vt[0]  = '{32'h00221821, 1'b0, 1'b0, 0, 4, 1, 5'd0,  2'd0, 2'd0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0}; // addu
    vt[1]  = '{32'h8C220004, 1'b0, 1'b0, 2, 7, 1, 5'd0,  2'd0, 2'd1, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0}; // lw, 2 waits
    vt[2]  = '{32'hAC220004, 1'b0, 1'b0, 0, 4, 0, 5'd0,  2'd0, 2'd1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1}; // sw
    vt[3]  = '{32'h10220003, 1'b1, 1'b0, 0, 3, 0, 5'd1,  2'd0, 2'd0, 1'b1, 2'd1, 2'd0, 2'd0, 1'b0}; // beq taken
    vt[4]  = '{32'h10220003, 1'b0, 1'b0, 0, 3, 0, 5'd1,  2'd0, 2'd0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0}; // beq not taken
    vt[5]  = '{32'h14220003, 1'b0, 1'b0, 0, 3, 0, 5'd1,  2'd0, 2'd0, 1'b1, 2'd1, 2'd0, 2'd0, 1'b0}; // bne taken
    vt[6]  = '{32'h00021900, 1'b0, 1'b0, 0, 4, 1, 5'd7,  2'd1, 2'd0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0}; // sll
    vt[7]  = '{32'h342200FF, 1'b0, 1'b0, 0, 4, 1, 5'd5,  2'd0, 2'd2, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0}; // ori
    vt[8]  = '{32'h3C021234, 1'b0, 1'b0, 0, 4, 1, 5'd16, 2'd0, 2'd1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0}; // lui
    vt[9]  = '{32'h08000010, 1'b0, 1'b0, 0, 3, 0, 5'd0,  2'd0, 2'd0, 1'b1, 2'd2, 2'd0, 2'd0, 1'b0}; // j
    vt[10] = '{32'h0C000010, 1'b0, 1'b0, 0, 3, 1, 5'd0,  2'd0, 2'd0, 1'b1, 2'd2, 2'd2, 2'd2, 1'b0}; // jal
    vt[11] = '{32'h03E00008, 1'b0, 1'b0, 0, 3, 0, 5'd11, 2'd0, 2'd0, 1'b1, 2'd3, 2'd0, 2'd0, 1'b0}; // jr
    vt[12] = '{32'h0040F809, 1'b0, 1'b0, 0, 3, 1, 5'd10, 2'd0, 2'd0, 1'b1, 2'd3, 2'd1, 2'd2, 1'b0}; // jalr
    vt[13] = '{32'h2422FFFF, 1'b0, 1'b1, 0, 4, 1, 5'd0,  2'd0, 2'd1, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0}; // addiu, ovf ignored
    vt[14] = '{32'h00221822, 1'b0, 1'b1, 0, 4, 1, 5'd1,  2'd0, 2'd0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0}; // sub, ovf ignored
    vt[15] = '{32'h0022182A, 1'b0, 1'b0, 1, 4, 1, 5'd2,  2'd0, 2'd0, 1'b0, 2'd0, 2'd1, 2'd0, 1'b0}; // slt (mwait unused)

    // Reset state: IF, no trap, strobes held low
    #1;
    chk("rst_state", o_state, ST_IF);
    chk("rst_trap", o_trap, 1'b0);
    chk("rst_mem_req", o_mem_req, 1'b0);
    chk("rst_pc_we", o_pc_we, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_instr(vt[i].ins, vt[i].z, vt[i].ov, vt[i].mwait, o);
      chk($sformatf("v%0d_cycles", i), o.cyc, vt[i].cyc);
      chk($sformatf("v%0d_reg_we_cnt", i), o.nregwe, vt[i].nregwe);
      chk($sformatf("v%0d_alu_op", i), o.alu, vt[i].alu);
      chk($sformatf("v%0d_src_a", i), o.sa, vt[i].sa);
      chk($sformatf("v%0d_src_b", i), o.sb, vt[i].sb);
      chk($sformatf("v%0d_pc_we_ex", i), o.pcwe, vt[i].pcwe);
      chk($sformatf("v%0d_pc_sel_ex", i), o.pcsel, vt[i].pcsel);
      chk($sformatf("v%0d_dst_sel", i), o.dst, vt[i].dst);
      chk($sformatf("v%0d_wb_sel", i), o.wb, vt[i].wb);
      chk($sformatf("v%0d_mem_we", i), o.memwe, vt[i].memwe);
      chk($sformatf("v%0d_end_state", i), o.st_end, ST_IF);
    end

    // add with overflow: TRAP_EN=0 writes back, TRAP_EN=1 halts without reg_we
    sel = 1'b1;
    c0 = rwe0_cnt;
    run_instr(32'h00221820, 1'b0, 1'b1, 0, o);
    chk("add_ovf_noTrap_cycles", o.cyc, 4);
    chk("add_ovf_noTrap_reg_we", o.nregwe, 1);
    chk("add_ovf_noTrap_end", o.st_end, ST_IF);
    sel = 1'b0;
    #1;
    chk("add_ovf_trap_state", o_state, ST_HALT);
    chk("add_ovf_trap_flag", o_trap, 1'b1);
    chk("add_ovf_trap_reg_we", rwe0_cnt - c0, 0);
    chk("halt_mem_req", o_mem_req, 1'b0);
    chk("halt_pc_we", o_pc_we, 1'b0);

    // Reset both instances back to IF
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst2_state", o_state, ST_IF);
    chk("rst2_trap", o_trap, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Illegal opcode 0x3F halts right after ID; HALT is absorbing
    run_instr(32'hFC000000, 1'b0, 1'b0, 0, o);
    chk("illegal_cycles", o.cyc, 2);
    chk("illegal_end", o.st_end, ST_HALT);
    chk("illegal_trap", o_trap, 1'b1);
    mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("halt_absorbing", o_state, ST_HALT);
    chk("halt_sticky_trap", o_trap, 1'b1);
    chk("halt_ir_we", o_reg_we | o_mem_req | o_pc_we, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("halt_rst_state", o_state, ST_IF);
    chk("halt_rst_trap", o_trap, 1'b0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("halt_rel_state", o_state, ST_IF);
    chk("halt_rel_mem_req", o_mem_req, 1'b1);

    // sw interrupted by reset while waiting in MEM
    instr = 32'hAC220004;
    zero = 1'b0;
    overflow = 1'b0;
    for (int k = 0; k < 10 && o_state != ST_MEM; k++) begin
      @(negedge clk);
      mem_ready = (o_state == ST_MEM) ? 1'b0 : 1'b1;
    end
    #1;
    chk("sw_mem_state", o_state, ST_MEM);
    chk("sw_mem_req", o_mem_req, 1'b1);
    chk("sw_mem_we", o_mem_we, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("sw_rst_mem_req", o_mem_req, 1'b0);
    chk("sw_rst_mem_we", o_mem_we, 1'b0);
    chk("sw_rst_state", o_state, ST_IF);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("sw_rel_state", o_state, ST_IF);
    chk("sw_rel_mem_req", o_mem_req, 1'b1);
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("sw_resume_id", o_state, ST_ID);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
